rosc_freq_meter: RTL and testbench
==================================

// Module: rosc_freq_meter
// PURPOSE
//  Measures the ring-oscillator output (raw or /2,/4,/8 tap) against the system clock.
//  Samples the asynchronous osc_in, counts its rising edges over a gated window of
//  2^(GATE_BASE_LOG2+gate_sel) clk cycles and presents the count with a valid/ack handshake.
//  Sits beside the ring/divider pair; it is the consumer that turns the tap frequency into a number.
// PARAMETERS
//  CNT_W           16  width of edge count / result; saturating
//  GATE_BASE_LOG2  8   log2 of the shortest gate window (gate_sel=0 -> 256 clk)
// PORTS
//  clk           in   1      system clock
//  rst_n         in   1      async active-low reset
//  ena           in   1      global enable; 0 holds the FSM in IDLE
//  osc_in        in   1      async oscillator tap; f_osc must be < f_clk/2
//  start         in   1      1-cycle request to begin a measurement (IDLE or DONE only)
//  cont          in   1      1: auto-restart after each ack
//  gate_sel      in   2      window = 2^(GATE_BASE_LOG2+gate_sel) clk cycles; latched at start
//  result        out  CNT_W  edge count of the last completed window
//  result_valid  out  1      result is stable and unacknowledged
//  result_ack    in   1      consumer takes result; honoured only when result_valid=1
//  busy          out  1      1 while in GATE
//  overflow      out  1      count saturated in the last window; qualified by result_valid
// BEHAVIOUR
//  - Reset: state=IDLE; result=0, result_valid=0, busy=0, overflow=0; sync flops and timers 0.
//  - osc_in -> 2-FF synchronizer -> rise = s2 & ~s3; runs continuously, not gated by state.
//  - FSM IDLE -> GATE -> DONE:
//    IDLE: start & ena at cycle t -> latch gate_sel, clear edge count/overflow, timer=N-1, GATE at t+1.
//    GATE: exactly N cycles (t+1..t+N); rise counted in each. Timer==0 -> DONE. busy=1.
//    DONE: result/overflow loaded on entry; result_valid=1 from t+N+1, held stable until ack.
//    DONE & result_ack: result_valid=0 next cycle; -> GATE if (start|cont)&ena, else IDLE.
//  - Edge count saturates at 2^CNT_W-1; a rise at saturation sets overflow; never wraps.
//  - start in GATE ignored (no queueing); start in DONE without ack ignored.
//  - result_ack without result_valid ignored; result unchanged.
//  - ena=0 during GATE: abort -> IDLE, result/result_valid unchanged from prior window.
//  - ena=0 in DONE: stays in DONE until ack, then IDLE regardless of cont.
//  - Async reset mid-window: all outputs to reset values immediately; no partial result.
//  - Resolution +/-1 edge (asynchronous phase); sync latency (2 clk) is constant, not corrected.
// STRUCTURE
//  - Package rosc_meter_pkg: state enum {IDLE,GATE,DONE}, gate_len(gate_sel) function,
//    GATE_SEL_W=2 constant.
//  - Sub-module sync_rise_detect: 2-FF synchronizer + rising-edge pulse, async reset to 0.
//  - Top: FSM, gate timer (GATE_BASE_LOG2+3 bits), saturating counter, result registers.
// TESTING
//  - osc_in period 4 clk (phase-locked), gate_sel=0, start -> result=64, overflow=0,
//    result_valid at start+257.
//  - osc_in held 0, gate_sel=3 -> result=0 after 2048 gate cycles, busy high exactly 2048 cycles.
//  - CNT_W=6, osc period 2 clk, gate_sel=0 -> result=63, overflow=1.
//  - start re-pulsed mid-GATE -> ignored; single result; ack then start in same cycle in DONE
//    -> result_valid low next cycle, busy high.
//  - cont=1, ack each result -> back-to-back windows with no IDLE cycle; results identical
//    for constant osc.
//  - rst_n low at cycle 100 of GATE -> result=0, result_valid=0, busy=0 at once; ena=0
//    mid-GATE keeps the prior result.

Source files
------------

// File: rtl/rosc_meter_pkg.sv
// Shared types and helpers for the ring-oscillator frequency meter.
package rosc_meter_pkg;

  localparam int unsigned GATE_SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    DONE = 2'd2
  } meter_state_e;

  // Gate window length in clk cycles: 2^(base_log2 + sel).
  function automatic int unsigned gate_len(input int unsigned base_log2,
                                           input logic [GATE_SEL_W-1:0] sel);
    return 32'd1 << (base_log2 + 32'(sel));
  endfunction

endpackage

// File: rtl/rosc_freq_meter_sync_rise_detect.sv
// Two-flop synchronizer for an asynchronous input plus a one-cycle rising-edge pulse.
module sync_rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o_c
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  // Synchronizer chain; s3 keeps the previous synchronized value for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_o_c = s2_q & ~s3_q;

endmodule

// File: rtl/rosc_freq_meter.sv
// Counts ring-oscillator rising edges over a gated clk window and hands the count out
// through a valid/ack handshake.
module rosc_freq_meter
  import rosc_meter_pkg::*;
#(
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned GATE_BASE_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  osc_in,
  input  logic                  start,
  input  logic                  cont,
  input  logic [GATE_SEL_W-1:0] gate_sel,
  output logic [CNT_W-1:0]      result,
  output logic                  result_valid,
  input  logic                  result_ack,
  output logic                  busy,
  output logic                  overflow
);

  localparam int unsigned TMR_W = GATE_BASE_LOG2 + 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  meter_state_e     state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_ovf_q, cnt_ovf_d;
  logic [CNT_W-1:0] result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic             busy_q, busy_d;
  logic             overflow_q, overflow_d;

  logic             rise;
  logic [CNT_W-1:0] cnt_inc;
  logic             ovf_inc;
  logic [TMR_W-1:0] gate_load;

  // Edge detector on the oscillator tap runs regardless of FSM state.
  sync_rise_detect u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_i  (osc_in),
    .rise_o_c (rise)
  );

  assign gate_load = TMR_W'(gate_len(GATE_BASE_LOG2, gate_sel) - 32'd1);

  // State, timer, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      cnt_q          <= '0;
      cnt_ovf_q      <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      cnt_q          <= cnt_d;
      cnt_ovf_q      <= cnt_ovf_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
      overflow_q     <= overflow_d;
    end
  end

  // Next-state logic: IDLE -> GATE -> DONE, with saturating edge count.
  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    cnt_d          = cnt_q;
    cnt_ovf_d      = cnt_ovf_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    overflow_d     = overflow_q;
    cnt_inc        = cnt_q;
    ovf_inc        = cnt_ovf_q;

    // Count that would result from this cycle's edge; sticks at max instead of wrapping.
    if (rise) begin
      if (cnt_q == CNT_MAX) begin
        ovf_inc = 1'b1;
      end else begin
        cnt_inc = cnt_q + CNT_W'(1);
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start && ena) begin
          state_d   = GATE;
          timer_d   = gate_load;
          cnt_d     = '0;
          cnt_ovf_d = 1'b0;
        end
      end
      GATE: begin
        if (!ena) begin
          // Abort: the previous result stays as it was.
          state_d = IDLE;
        end else begin
          cnt_d     = cnt_inc;
          cnt_ovf_d = ovf_inc;
          if (timer_q == '0) begin
            state_d        = DONE;
            result_d       = cnt_inc;
            overflow_d     = ovf_inc;
            result_valid_d = 1'b1;
          end else begin
            timer_d = timer_q - TMR_W'(1);
          end
        end
      end
      DONE: begin
        if (result_ack) begin
          result_valid_d = 1'b0;
          if ((start || cont) && ena) begin
            state_d   = GATE;
            timer_d   = gate_load;
            cnt_d     = '0;
            cnt_ovf_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == GATE);
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_rosc_freq_meter.sv
// Directed test of rosc_freq_meter with a phase-locked synthetic oscillator.
module tb_rosc_freq_meter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic        osc_in = 1'b0;
  logic        start = 1'b0;
  logic        cont = 1'b0;
  logic        result_ack = 1'b0;
  logic [1:0]  gate_sel = 2'd0;

  logic [15:0] result;
  logic        result_valid, busy, overflow;
  logic [5:0]  result6;
  logic        valid6, busy6, ovf6;

  int vectors = 0;
  int miscompares = 0;
  int osc_period = 0;
  int osc_ph = 0;

  rosc_freq_meter #(.CNT_W(16), .GATE_BASE_LOG2(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .osc_in(osc_in), .start(start), .cont(cont),
    .gate_sel(gate_sel), .result(result), .result_valid(result_valid),
    .result_ack(result_ack), .busy(busy), .overflow(overflow)
  );

  rosc_freq_meter #(.CNT_W(6), .GATE_BASE_LOG2(8)) dut6 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .osc_in(osc_in), .start(start), .cont(cont),
    .gate_sel(gate_sel), .result(result6), .result_valid(valid6),
    .result_ack(result_ack), .busy(busy6), .overflow(ovf6)
  );

  always #5 clk = ~clk;

  // Oscillator changes on the falling clk edge; period given in clk cycles (0 = held low).
  always @(negedge clk) begin
    if (osc_period < 2) begin
      osc_in = 1'b0;
    end else begin
      osc_ph = osc_ph + 1;
      if (osc_ph >= osc_period) osc_ph = 0;
      osc_in = (osc_ph < osc_period / 2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int limit, output int cycles);
    cycles = 0;
    while (!result_valid && cycles < limit) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ena   = 1'b1;
    repeat (3) tick();
    vectors++; if (result !== 16'd0) begin miscompares++; $display("FAIL reset_result: got %0d want 0", result); end
    vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", result_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    osc_period = 4;
    gate_sel   = 2'd0;
    repeat (8) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy_start: got %b want 1", busy); end
    repeat (255) tick();
    vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("FAIL basic_valid_early: got %b want 0", result_valid); end
    tick();
    vectors++; if (result_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid_257: got %b want 1", result_valid); end
    vectors++; if (result !== 16'd64) begin miscompares++; $display("FAIL basic_result: got %0d want 64", result); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL basic_overflow: got %b want 0", overflow); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_done: got %b want 0", busy); end
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    vectors++; if ({result_valid, busy} !== 2'b00) begin miscompares++; $display("FAIL basic_ack: got valid,busy=%b want 00", {result_valid, busy}); end
    vectors++; if (result !== 16'd64) begin miscompares++; $display("FAIL basic_result_held: got %0d want 64", result); end
  endtask

  task automatic test_saturate();
    int c;
    osc_period = 2;
    repeat (8) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(300, c);
    vectors++; if (c != 256) begin miscompares++; $display("FAIL sat_latency: got %0d want 256", c); end
    vectors++; if (result6 !== 6'd63) begin miscompares++; $display("FAIL sat_result6: got %0d want 63", result6); end
    vectors++; if (ovf6 !== 1'b1) begin miscompares++; $display("FAIL sat_overflow6: got %b want 1", ovf6); end
    vectors++; if (result !== 16'd128) begin miscompares++; $display("FAIL sat_result16: got %0d want 128", result); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL sat_overflow16: got %b want 0", overflow); end
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
  endtask

  task automatic test_zero_long();
    int c;
    int n;
    osc_period = 0;
    repeat (8) tick();
    gate_sel = 2'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    gate_sel = 2'd0;
    n = 0;
    c = 0;
    while (!result_valid && c < 2100) begin
      if (busy) n++;
      tick();
      c++;
    end
    vectors++; if (result_valid !== 1'b1) begin miscompares++; $display("FAIL zero_timeout: got valid %b want 1", result_valid); end
    vectors++; if (n != 2048) begin miscompares++; $display("FAIL zero_busy_cycles: got %0d want 2048", n); end
    vectors++; if (result !== 16'd0) begin miscompares++; $display("FAIL zero_result: got %0d want 0", result); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL zero_overflow: got %b want 0", overflow); end
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
  endtask

  task automatic test_restart_ignored();
    int c;
    osc_period = 4;
    repeat (8) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (49) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (205) tick();
    vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("FAIL restart_valid_early: got %b want 0", result_valid); end
    tick();
    vectors++; if (result_valid !== 1'b1) begin miscompares++; $display("FAIL restart_valid: got %b want 1", result_valid); end
    vectors++; if (result !== 16'd64) begin miscompares++; $display("FAIL restart_result: got %0d want 64", result); end
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++; if ({result_valid, busy} !== 2'b10) begin miscompares++; $display("FAIL done_start_noack: got valid,busy=%b want 10", {result_valid, busy}); end
    result_ack = 1'b1;
    start = 1'b1;
    tick();
    result_ack = 1'b0;
    start = 1'b0;
    vectors++; if ({result_valid, busy} !== 2'b01) begin miscompares++; $display("FAIL ack_start: got valid,busy=%b want 01", {result_valid, busy}); end
    wait_valid(300, c);
    vectors++; if (c != 256) begin miscompares++; $display("FAIL ack_start_latency: got %0d want 256", c); end
    vectors++; if (result !== 16'd64) begin miscompares++; $display("FAIL ack_start_result: got %0d want 64", result); end
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    int c;
    cont = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(300, c);
    vectors++; if (c != 256) begin miscompares++; $display("FAIL b2b_first_latency: got %0d want 256", c); end
    for (int w = 0; w < 3; w++) begin
      vectors++; if (result !== 16'd64) begin miscompares++; $display("FAIL b2b_result_%0d: got %0d want 64", w, result); end
      result_ack = 1'b1;
      tick();
      result_ack = 1'b0;
      vectors++; if ({result_valid, busy} !== 2'b01) begin miscompares++; $display("FAIL b2b_restart_%0d: got valid,busy=%b want 01", w, {result_valid, busy}); end
      wait_valid(300, c);
      vectors++; if (c != 256) begin miscompares++; $display("FAIL b2b_latency_%0d: got %0d want 256", w, c); end
    end
    vectors++; if (result !== 16'd64) begin miscompares++; $display("FAIL b2b_result_last: got %0d want 64", result); end
    cont = 1'b0;
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    vectors++; if ({result_valid, busy} !== 2'b00) begin miscompares++; $display("FAIL b2b_stop: got valid,busy=%b want 00", {result_valid, busy}); end
  endtask

  task automatic test_ena_abort();
    ena = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ena_low_start: got busy %b want 0", busy); end
    ena = 1'b1;
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    vectors++; if ({result_valid, result} !== {1'b0, 16'd64}) begin miscompares++; $display("FAIL stray_ack: got valid %b result %0d want 0 64", result_valid, result); end
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL abort_busy_start: got %b want 1", busy); end
    repeat (20) tick();
    ena = 1'b0;
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b want 0", busy); end
    repeat (300) tick();
    vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("FAIL abort_valid: got %b want 0", result_valid); end
    vectors++; if (result !== 16'd64) begin miscompares++; $display("FAIL abort_result: got %0d want 64", result); end
    ena = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (99) tick();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (result !== 16'd0) begin miscompares++; $display("FAIL midrst_result: got %0d want 0", result); end
    vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid: got %b want 0", result_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b want 0", busy); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL midrst_overflow: got %b want 0", overflow); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_zero_long();
    test_restart_ignored();
    test_back_to_back();
    test_ena_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
